// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that lets N_REQ requesters share one
// registered adder. One transaction is in flight at a time: the winner's
// operands are latched, the adder latency is waited out, and the sum is held
// for the consumer until it is taken.
module adder_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int ADD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH:0]             add_c,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH:0]             rsp_sum,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [ID_W-1:0]    ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               found_s;
    logic [ID_W-1:0]    gidx_s;
    logic [N_REQ-1:0]   grant_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic               accept_s;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        found_s = 1'b0;
        gidx_s  = '0;
        cand_v  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_v = {1'b0, ptr_r} + IDX_W'(k);
            if (cand_v >= IDX_W'(N_REQ)) begin
                cand_v = cand_v - IDX_W'(N_REQ);
            end else begin
                cand_v = cand_v;
            end
            if (!found_s && req_valid[cand_v[ID_W-1:0]]) begin
                found_s = 1'b1;
                gidx_s  = cand_v[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant and winner operand mux; grants only exist in IDLE.
    always_comb begin
        grant_s = '0;
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_s[i] = (state_r == ST_IDLE) && found_s && (gidx_s == ID_W'(i));
            sel_a_s = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            sel_b_s = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: WAIT ends when the latency counter has run out.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_WAIT;
                else          state_next_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == '0) state_next_s = ST_RESP;
                else             state_next_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready) state_next_s = ST_IDLE;
                else           state_next_s = ST_WAIT == state_r ? ST_WAIT : ST_RESP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: operand/id latch on accept, latency count, result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r     <= '0;
            cnt_r     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        add_a  <= sel_a_s;
                        add_b  <= sel_b_s;
                        rsp_id <= gidx_s;
                        cnt_r  <= CNT_LOAD;
                        ptr_r  <= (gidx_s == LAST_ID) ? '0 : gidx_s + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == '0) begin
                        rsp_sum   <= add_c;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter (N_REQ=4, WIDTH=8, ADD_LAT=1).
// The bench supplies a one-cycle registered adder model on add_a/add_b.
module tb_adder_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [8:0]  add_c;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_sum;
    logic        rsp_ready;
    logic        busy;

    int checks;
    int errors;

    adder_arbiter #(.N_REQ(4), .WIDTH(8), .ADD_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder model with one cycle of registered latency.
    always_ff @(posedge clk) begin
        add_c <= {1'b0, add_a} + {1'b0, add_b};
    end

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_sum, add_a, add_b} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b vld=%b id=%0d sum=%h a=%h b=%h expected all zero",
                     busy, rsp_valid, rsp_id, rsp_sum, add_a, add_b);
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL reset_grant: got %b expected %b", req_ready, 4'b0010);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rsp_ready_ignored: got vld=%b busy=%b expected 0 0", rsp_valid, busy);
        end
        rsp_ready = 1'b0;
        set_lane(2, 8'h7F, 8'h01);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b expected %b", req_ready, 4'b0100);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++;
        if ({busy, req_ready, rsp_valid, add_a, add_b} !== {1'b1, 4'b0000, 1'b0, 8'h7F, 8'h01}) begin
            errors++;
            $display("FAIL single_wait: got busy=%b rdy=%b vld=%b a=%h b=%h expected 1 0000 0 7f 01",
                     busy, req_ready, rsp_valid, add_a, add_b);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got rsp_valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd2, 9'h080}) begin
            errors++;
            $display("FAIL single_rsp: got vld=%b id=%0d sum=%h expected 1 2 080", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got vld=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_overflow();
        set_lane(3, 8'hFF, 8'hFF);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL overflow_grant: got %b expected %b", req_ready, 4'b1000);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd3, 9'h1FE}) begin
            errors++;
            $display("FAIL overflow_rsp: got vld=%b id=%0d sum=%h expected 1 3 1fe", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int n;
        int rsp_seen;
        logic [3:0] exp_m;
        logic [1:0] prev_id;
        logic [8:0] exp_sum;
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 8'(16 * (i + 1)), 8'(i + 1));
        end
        rsp_seen  = 0;
        prev_id   = 2'd0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 1;
            while (req_ready === 4'b0000 && n < 12) begin
                if (rsp_valid === 1'b1) begin
                    rsp_seen++;
                    exp_sum = 9'(17 * (prev_id + 1));
                    checks++;
                    if (rsp_id !== prev_id || rsp_sum !== exp_sum) begin
                        errors++;
                        $display("FAIL fair_rsp: got id=%0d sum=%h expected %0d %h", rsp_id, rsp_sum, prev_id, exp_sum);
                    end
                end
                @(negedge clk);
                n++;
            end
            exp_m = 4'b0001 << (g % 4);
            checks++;
            if (req_ready !== exp_m) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b expected %b", g, req_ready, exp_m);
            end
            if (g > 0) begin
                checks++;
                if (n !== 4) begin
                    errors++;
                    $display("FAIL fair_gap%0d: got %0d cycles expected 4", g, n);
                end
            end
            prev_id = 2'(g % 4);
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_seen !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fair_drain: got rsp_seen=%0d busy=%b expected 4 0", rsp_seen, busy);
        end
    endtask

    task automatic test_backpressure();
        set_lane(1, 8'h33, 8'h44);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant: got %b expected %b", req_ready, 4'b0010);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_sum, req_ready, busy} !== {1'b1, 2'd1, 9'h077, 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b id=%0d sum=%h rdy=%b busy=%b expected 1 1 077 0000 1",
                         c, rsp_valid, rsp_id, rsp_sum, req_ready, busy);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b0100}) begin
            errors++;
            $display("FAIL bp_release: got vld=%b busy=%b rdy=%b expected 0 0 0100", rsp_valid, busy, req_ready);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ptr_skip();
        set_lane(3, 8'h0A, 8'h05);
        set_lane(0, 8'h01, 8'h02);
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL skip_grant3: got %b expected %b", req_ready, 4'b1000);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd3, 9'h00F}) begin
            errors++;
            $display("FAIL skip_rsp3: got vld=%b id=%0d sum=%h expected 1 3 00f", rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL skip_grant0: got %b expected %b", req_ready, 4'b0001);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 9'h003}) begin
            errors++;
            $display("FAIL skip_rsp0: got vld=%b id=%0d sum=%h expected 1 0 003", rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_wait();
        int seen;
        set_lane(1, 8'h55, 8'h22);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rw_in_wait: got busy=%b expected 1", busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_sum, add_a, add_b} !== 29'd0) begin
            errors++;
            $display("FAIL rw_reset_outputs: got busy=%b vld=%b id=%0d sum=%h a=%h b=%h expected all zero",
                     busy, rsp_valid, rsp_id, rsp_sum, add_a, add_b);
        end
        @(negedge clk);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        seen      = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rw_no_rsp: got %0d active cycles expected 0", seen);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rw_grant: got %b expected %b", req_ready, 4'b0001);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_ptr_skip();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
